// File: rtl/mem_io_responder_pkg.sv
// Memory map constants and timer register layout shared by the responder and its timer.
package mem_map_pkg;
    localparam logic [15:0] LED_ADDR_DEF = 16'h1000;
    localparam logic [15:0] TMR_BASE_DEF = 16'h2000;
    localparam logic [15:0] SW_ADDR_DEF  = 16'h3000;

    localparam logic [1:0] TMR_OFF_LOAD  = 2'd0;
    localparam logic [1:0] TMR_OFF_CTRL  = 2'd1;
    localparam logic [1:0] TMR_OFF_COUNT = 2'd2;
    localparam logic [1:0] TMR_OFF_STAT  = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int STAT_EXP  = 0;

    typedef enum logic [1:0] {
        TK_HOLD,
        TK_DEC,
        TK_EXPIRE
    } tick_e;
endpackage

// File: rtl/mem_io_responder_if.sv
// Processor-side bus: word address, write data, write strobe and registered read data.
interface mem_io_responder_if;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] DIN;

    modport master (output ADDR, output DOUT, output W, input DIN);
    modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/mem_io_responder_timer16.sv
// 16-bit down-counting timer: LOAD/CTRL/COUNT/STATUS registers with one-shot and auto-reload modes.
module timer16
    import mem_map_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_off,
    input  logic        i_wr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_irq
);
    logic [15:0] r_load, r_count;
    logic        r_en, r_auto, r_exp;
    logic [15:0] w_load_n, w_count_n;
    logic        w_en_n, w_auto_n, w_exp_n;
    logic        w_wr_load, w_wr_ctrl, w_wr_stat;
    tick_e       w_tick;

    assign w_wr_load = i_wr && (i_off == TMR_OFF_LOAD);
    assign w_wr_ctrl = i_wr && (i_off == TMR_OFF_CTRL);
    assign w_wr_stat = i_wr && (i_off == TMR_OFF_STAT);

    // A LOAD write replaces this cycle's tick entirely.
    always_comb begin
        w_tick = TK_HOLD;
        if (r_en && !w_wr_load)
            w_tick = (r_count > 16'd1) ? TK_DEC : TK_EXPIRE;
    end

    always_comb begin
        w_load_n  = r_load;
        w_count_n = r_count;
        w_en_n    = r_en;
        w_auto_n  = r_auto;
        w_exp_n   = r_exp;
        case (w_tick)
            TK_DEC:    w_count_n = r_count - 16'd1;
            TK_EXPIRE: begin
                w_count_n = (r_count == 16'd0 && r_auto) ? r_load : 16'd0;
                if (!r_auto)
                    w_en_n = 1'b0;
            end
            default:   ;
        endcase
        if (w_wr_load) begin
            w_load_n  = i_wdata;
            w_count_n = i_wdata;
        end
        if (w_wr_ctrl) begin
            w_en_n   = i_wdata[CTRL_EN];
            w_auto_n = i_wdata[CTRL_AUTO];
        end
        if (w_wr_stat && i_wdata[STAT_EXP])
            w_exp_n = 1'b0;
        if (w_tick == TK_EXPIRE)
            w_exp_n = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load  <= 16'd0;
            r_count <= 16'd0;
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_exp   <= 1'b0;
        end else begin
            r_load  <= w_load_n;
            r_count <= w_count_n;
            r_en    <= w_en_n;
            r_auto  <= w_auto_n;
            r_exp   <= w_exp_n;
        end
    end

    always_comb begin
        o_rdata = 16'h0000;
        case (i_off)
            TMR_OFF_LOAD:  o_rdata = r_load;
            TMR_OFF_CTRL:  o_rdata = {14'd0, r_auto, r_en};
            TMR_OFF_COUNT: o_rdata = r_count;
            TMR_OFF_STAT:  o_rdata = {15'd0, r_exp};
            default:       o_rdata = 16'h0000;
        endcase
    end

    assign o_irq = r_exp;
endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: RAM, LED register, synchronised switches and timer behind one
// registered read port with fixed 1-cycle latency and read-first semantics.
module mem_io_responder
    import mem_map_pkg::*;
#(
    parameter int          RAM_AW   = 7,
    parameter logic [15:0] LED_ADDR = LED_ADDR_DEF,
    parameter logic [15:0] TMR_BASE = TMR_BASE_DEF,
    parameter logic [15:0] SW_ADDR  = SW_ADDR_DEF
) (
    input  logic                clock,
    input  logic                resetN,
    mem_io_responder_if.slave   bus,
    input  logic [9:0]          SW,
    output logic [9:0]          LEDR,
    output logic                tmr_irq
);
    localparam int RAM_DEPTH = 2 ** RAM_AW;

    logic [15:0] r_ram [RAM_DEPTH];
    logic [15:0] r_din;
    logic [9:0]  r_led, r_sw_s1, r_sw_s2;
    logic        w_ram_hit, w_led_hit, w_sw_hit, w_tmr_hit;
    logic [15:0] w_tmr_off, w_ram_rd, w_tmr_rdata, w_rdata;

    assign w_tmr_off = bus.ADDR - TMR_BASE;
    assign w_ram_hit = (bus.ADDR[15:RAM_AW] == '0);
    assign w_led_hit = (bus.ADDR == LED_ADDR);
    assign w_sw_hit  = (bus.ADDR == SW_ADDR);
    assign w_tmr_hit = (w_tmr_off[15:2] == 14'd0);

    // RAM contents survive reset; only the write port is clocked here.
    always_ff @(posedge clock) begin
        if (bus.W && w_ram_hit)
            r_ram[bus.ADDR[RAM_AW-1:0]] <= bus.DOUT;
    end
    assign w_ram_rd = r_ram[bus.ADDR[RAM_AW-1:0]];

    timer16 u_timer (
        .clk     (clock),
        .rst     (resetN),
        .i_off   (w_tmr_off[1:0]),
        .i_wr    (bus.W && w_tmr_hit && !w_ram_hit),
        .i_wdata (bus.DOUT),
        .o_rdata (w_tmr_rdata),
        .o_irq   (tmr_irq)
    );

    always_comb begin
        w_rdata = 16'h0000;
        if (w_ram_hit)      w_rdata = w_ram_rd;
        else if (w_led_hit) w_rdata = {6'd0, r_led};
        else if (w_sw_hit)  w_rdata = {6'd0, r_sw_s2};
        else if (w_tmr_hit) w_rdata = w_tmr_rdata;
    end

    always_ff @(posedge clock or posedge resetN) begin
        if (resetN) begin
            r_din   <= 16'h0000;
            r_led   <= 10'd0;
            r_sw_s1 <= 10'd0;
            r_sw_s2 <= 10'd0;
        end else begin
            r_din   <= w_rdata;
            r_sw_s1 <= SW;
            r_sw_s2 <= r_sw_s1;
            if (bus.W && w_led_hit && !w_ram_hit)
                r_led <= bus.DOUT[9:0];
        end
    end

    assign bus.DIN = r_din;
    assign LEDR    = r_led;
endmodule

// File: tb/tb_mem_io_responder.sv
// Randomised and directed checks of the responder against a cycle-level behavioural model.
module tb_mem_io_responder;
  import mem_map_pkg::*;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic [9:0] SW = 10'd0;
  logic [9:0] LEDR;
  logic tmr_irq;
  int total = 0;
  int bad = 0;

  mem_io_responder_if bus();

  mem_io_responder dut (
    .clock(clock), .resetN(resetN), .bus(bus),
    .SW(SW), .LEDR(LEDR), .tmr_irq(tmr_irq)
  );

  always #5 clock = ~clock;

  // behavioural model state
  logic [15:0] m_mem [128];
  logic [9:0]  m_led, m_s1, m_s2;
  int          m_load, m_count;
  bit          m_en, m_auto, m_exp;
  logic [15:0] exp_din;

  function automatic logic [15:0] m_read(input logic [15:0] a);
    int off;
    off = int'(a) - int'(TMR_BASE_DEF);
    if (a < 16'd128)              return m_mem[a[6:0]];
    if (a == LED_ADDR_DEF)        return {6'd0, m_led};
    if (a == SW_ADDR_DEF)         return {6'd0, m_s2};
    if (off == 0)                 return 16'(m_load);
    if (off == 1)                 return {14'd0, m_auto, m_en};
    if (off == 2)                 return 16'(m_count);
    if (off == 3)                 return {15'd0, m_exp};
    return 16'h0000;
  endfunction

  task automatic m_reset();
    m_led = 0; m_s1 = 0; m_s2 = 0;
    m_load = 0; m_count = 0; m_en = 0; m_auto = 0; m_exp = 0;
  endtask

  // One bus cycle: drive, record the expected read (old contents), step the model after the edge.
  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w);
    int off;
    bit expired;
    bus.ADDR = a; bus.DOUT = d; bus.W = w;
    exp_din = m_read(a);
    @(posedge clock); #1;
    off = int'(a) - int'(TMR_BASE_DEF);
    expired = 0;
    if (w && off == 0) begin
      m_load = int'(d); m_count = int'(d);
    end else if (m_en) begin
      if (m_count > 1) m_count = m_count - 1;
      else begin
        expired = 1;
        m_count = (m_count == 0 && m_auto) ? m_load : 0;
        if (!m_auto) m_en = 0;
      end
    end
    if (w && off == 1) begin m_en = d[0]; m_auto = d[1]; end
    if (w && off == 3 && d[0]) m_exp = 0;
    if (expired) m_exp = 1;
    if (w && a < 16'd128) m_mem[a[6:0]] = d;
    if (w && a == LED_ADDR_DEF) m_led = d[9:0];
    m_s2 = m_s1; m_s1 = SW;
    bus.W = 1'b0;
  endtask

  task automatic test_reset();
    bus.ADDR = 16'h0; bus.DOUT = 16'h0; bus.W = 1'b0;
    resetN = 1'b1; #1;
    m_reset();
    total++; if (bus.DIN !== 16'h0) begin bad++; $display("FAIL reset_din got=%h want=0000", bus.DIN); end
    total++; if (LEDR !== 10'h0) begin bad++; $display("FAIL reset_ledr got=%h want=000", LEDR); end
    total++; if (tmr_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", tmr_irq); end
    @(negedge clock); resetN = 1'b0;
    for (int i = 0; i < 128; i++) cyc(16'(i), 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(TMR_BASE_DEF + 16'(i % 4), 16'h0, 1'b0);
      if (i > 0) begin
        total++; if (bus.DIN !== 16'h0) begin bad++; $display("FAIL reset_tmr_reg%0d got=%h want=0000", i % 4, bus.DIN); end
      end
    end
  endtask

  task automatic test_ram();
    logic [15:0] a, d;
    cyc(16'h0005, 16'hBEEF, 1'b1);
    cyc(16'h0005, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'hBEEF) begin bad++; $display("FAIL ram_read5 got=%h want=beef", bus.DIN); end
    cyc(16'h0006, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'h0000) begin bad++; $display("FAIL ram_read6 got=%h want=0000", bus.DIN); end
    for (int i = 0; i < 60; i++) begin
      a = 16'(32 + $urandom_range(0, 95));
      d = 16'($urandom);
      cyc(a, d, 1'($urandom_range(0, 1)));
      total++; if (bus.DIN !== exp_din) begin bad++; $display("FAIL ram_rand addr=%h got=%h want=%h", a, bus.DIN, exp_din); end
    end
  endtask

  task automatic test_read_first();
    cyc(16'h0010, 16'h1234, 1'b1);
    cyc(16'h0010, 16'h5678, 1'b1);
    total++; if (bus.DIN !== 16'h1234) begin bad++; $display("FAIL rdfirst_old got=%h want=1234", bus.DIN); end
    cyc(16'h0010, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'h5678) begin bad++; $display("FAIL rdfirst_new got=%h want=5678", bus.DIN); end
    cyc(LED_ADDR_DEF, 16'h0011, 1'b1);
    cyc(LED_ADDR_DEF, 16'h0022, 1'b1);
    total++; if (bus.DIN !== 16'h0011) begin bad++; $display("FAIL rdfirst_led got=%h want=0011", bus.DIN); end
  endtask

  task automatic test_map();
    logic [15:0] a;
    cyc(LED_ADDR_DEF, 16'h03FF, 1'b1);
    total++; if (LEDR !== 10'h3FF) begin bad++; $display("FAIL led_write got=%h want=3ff", LEDR); end
    cyc(LED_ADDR_DEF, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'h03FF) begin bad++; $display("FAIL led_read got=%h want=03ff", bus.DIN); end
    cyc(16'h4000, 16'hFFFF, 1'b1);
    cyc(16'h4000, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'h0000) begin bad++; $display("FAIL unmapped_read got=%h want=0000", bus.DIN); end
    total++; if (LEDR !== 10'h3FF) begin bad++; $display("FAIL unmapped_led got=%h want=3ff", LEDR); end
    SW = 10'h155;
    cyc(SW_ADDR_DEF, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'h0000) begin bad++; $display("FAIL sw_early got=%h want=0000", bus.DIN); end
    cyc(SW_ADDR_DEF, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'h0000) begin bad++; $display("FAIL sw_early2 got=%h want=0000", bus.DIN); end
    cyc(SW_ADDR_DEF, 16'hFFFF, 1'b1);
    total++; if (bus.DIN !== 16'h0155) begin bad++; $display("FAIL sw_sync got=%h want=0155", bus.DIN); end
    cyc(SW_ADDR_DEF, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'h0155) begin bad++; $display("FAIL sw_readonly got=%h want=0155", bus.DIN); end
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 16'(32 + $urandom_range(0, 95));
        1: a = LED_ADDR_DEF;
        2: a = SW_ADDR_DEF;
        default: a = 16'h4000 + 16'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 3) == 0) SW = 10'($urandom);
      cyc(a, 16'($urandom), 1'($urandom_range(0, 1)));
      total++; if (bus.DIN !== exp_din) begin bad++; $display("FAIL map_rand addr=%h got=%h want=%h", a, bus.DIN, exp_din); end
      total++; if (LEDR !== m_led) begin bad++; $display("FAIL map_rand_led got=%h want=%h", LEDR, m_led); end
    end
  endtask

  task automatic test_timer_oneshot();
    logic [15:0] want_din [5];
    logic        want_irq [5];
    want_din = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
    want_irq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    cyc(TMR_BASE_DEF + 16'd0, 16'd3, 1'b1);
    cyc(TMR_BASE_DEF + 16'd1, 16'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(TMR_BASE_DEF + 16'd2, 16'h0, 1'b0);
      total++; if (bus.DIN !== want_din[i]) begin bad++; $display("FAIL oneshot_count%0d got=%h want=%h", i, bus.DIN, want_din[i]); end
      total++; if (tmr_irq !== want_irq[i]) begin bad++; $display("FAIL oneshot_irq%0d got=%b want=%b", i, tmr_irq, want_irq[i]); end
    end
    cyc(TMR_BASE_DEF + 16'd1, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'h0000) begin bad++; $display("FAIL oneshot_ctrl got=%h want=0000", bus.DIN); end
    cyc(TMR_BASE_DEF + 16'd3, 16'h1, 1'b1);
    total++; if (tmr_irq !== 1'b0) begin bad++; $display("FAIL oneshot_w1c got=%b want=0", tmr_irq); end
  endtask

  task automatic test_timer_auto();
    logic [15:0] want_din [8];
    bit found;
    want_din = '{16'd2, 16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd2, 16'd1};
    cyc(TMR_BASE_DEF + 16'd0, 16'd2, 1'b1);
    cyc(TMR_BASE_DEF + 16'd1, 16'd3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(TMR_BASE_DEF + 16'd2, 16'h0, 1'b0);
      total++; if (bus.DIN !== want_din[i]) begin bad++; $display("FAIL auto_count%0d got=%h want=%h", i, bus.DIN, want_din[i]); end
    end
    total++; if (tmr_irq !== 1'b1) begin bad++; $display("FAIL auto_irq got=%b want=1", tmr_irq); end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_count == 2) found = 1;
      else cyc(TMR_BASE_DEF + 16'd2, 16'h0, 1'b0);
    end
    total++; if (!found) begin bad++; $display("FAIL auto_wait_count2 got=timeout want=count2"); end
    cyc(TMR_BASE_DEF + 16'd3, 16'h1, 1'b1);
    total++; if (tmr_irq !== 1'b0) begin bad++; $display("FAIL auto_w1c got=%b want=0", tmr_irq); end
    cyc(TMR_BASE_DEF + 16'd3, 16'h1, 1'b1);
    total++; if (tmr_irq !== 1'b1) begin bad++; $display("FAIL auto_set_wins got=%b want=1", tmr_irq); end
    cyc(TMR_BASE_DEF + 16'd1, 16'h0, 1'b1);
    cyc(TMR_BASE_DEF + 16'd3, 16'h1, 1'b1);
  endtask

  task automatic test_timer_random();
    logic [15:0] a;
    for (int r = 0; r < 4; r++) begin
      cyc(TMR_BASE_DEF + 16'd0, 16'($urandom_range(0, 6)), 1'b1);
      cyc(TMR_BASE_DEF + 16'd1, 16'($urandom_range(0, 1) * 2 + 1), 1'b1);
      for (int i = 0; i < 16; i++) begin
        a = TMR_BASE_DEF + 16'($urandom_range(0, 3));
        cyc(a, 16'h0, 1'b0);
        total++; if (bus.DIN !== exp_din) begin bad++; $display("FAIL tmr_rand addr=%h got=%h want=%h", a, bus.DIN, exp_din); end
        total++; if (tmr_irq !== m_exp) begin bad++; $display("FAIL tmr_rand_irq got=%b want=%b", tmr_irq, m_exp); end
      end
      cyc(TMR_BASE_DEF + 16'd1, 16'h0, 1'b1);
      cyc(TMR_BASE_DEF + 16'd3, 16'h1, 1'b1);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    cyc(LED_ADDR_DEF, 16'h00AA, 1'b1);
    cyc(TMR_BASE_DEF + 16'd0, 16'd8, 1'b1);
    cyc(TMR_BASE_DEF + 16'd1, 16'd1, 1'b1);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_count == 5) found = 1;
      else cyc(16'h0005, 16'h0, 1'b0);
    end
    total++; if (!found) begin bad++; $display("FAIL rst_wait_count5 got=timeout want=count5"); end
    total++; if (bus.DIN !== 16'hBEEF) begin bad++; $display("FAIL rst_pre_din got=%h want=beef", bus.DIN); end
    #2 resetN = 1'b1; #1;
    m_reset();
    total++; if (bus.DIN !== 16'h0) begin bad++; $display("FAIL rst_din got=%h want=0000", bus.DIN); end
    total++; if (LEDR !== 10'h0) begin bad++; $display("FAIL rst_ledr got=%h want=000", LEDR); end
    total++; if (tmr_irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", tmr_irq); end
    @(negedge clock); resetN = 1'b0;
    cyc(TMR_BASE_DEF + 16'd2, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'h0) begin bad++; $display("FAIL rst_count got=%h want=0000", bus.DIN); end
    cyc(TMR_BASE_DEF + 16'd1, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'h0) begin bad++; $display("FAIL rst_ctrl got=%h want=0000", bus.DIN); end
    cyc(16'h0005, 16'h0, 1'b0);
    total++; if (bus.DIN !== 16'hBEEF) begin bad++; $display("FAIL rst_ram_kept got=%h want=beef", bus.DIN); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_read_first();
    test_map();
    test_timer_oneshot();
    test_timer_auto();
    test_timer_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Memory-side responder for the processor's ADDR/DOUT/W/DIN bus. It turns processor fetches, loads and stores into responses from four sources:
- a synchronous 128x16 RAM;
- a memory-mapped LED register;
- a synchronised switch port;
- a 16-bit down-counting timer.

It sits between the processor and the board I/O and drives the processor's DIN.

Parameters:
- RAM_AW, 7, RAM address width in words (depth = 2**RAM_AW).
- LED_ADDR, 16'h1000, LED register address.
- TMR_BASE, 16'h2000, timer base address (4 consecutive words).
- SW_ADDR, 16'h3000, switch port address.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-high reset (the name is historical; high = reset).
- ADDR  in  16  word address from the processor.
- DOUT  in  16  write data from the processor.
- W  in  1  write strobe; when high, a write to ADDR with DOUT is committed at the rising edge.
- DIN  out  16  registered read data to the processor.
- SW  in  10  raw board switches (asynchronous).
- LEDR  out  10  LED register bits [9:0].
- tmr_irq  out  1  timer expired flag (level).

Behaviour:
- Reset (asynchronous, resetN=1):
  - DIN=0, LEDR=0, tmr_irq=0.
  - Timer LOAD=0, COUNT=0, CTRL=0, STATUS=0.
  - Switch synchroniser flops = 0.
  - RAM contents are NOT reset.
- Address decode:
  - RAM hits when ADDR[15:RAM_AW]==0.
  - LED, SW and timer hits are exact matches (timer: TMR_BASE+0..3).
  - Any other address is unmapped.
- Read path, fixed 1-cycle latency:
  - DIN at edge t+1 = contents of ADDR sampled at edge t. The processor relies on this: its address register is loaded one step before DIN is used.
  - DIN updates every cycle regardless of W.
- Read-during-write to the same address returns the OLD value (read-first). This holds for RAM and for all registers.
- Register reads:
  - Unmapped address returns 16'h0000.
  - LED returns {6'b0, LEDR}.
  - SW returns {6'b0, sw_sync}, where sw_sync is the two-flop synchronised SW.
- Writes (W=1 at an edge):
  - RAM: RAM[ADDR[RAM_AW-1:0]] <= DOUT.
  - LED: LEDR <= DOUT[9:0].
  - SW: read-only, write ignored.
  - Unmapped: write ignored.
- Timer register map:
  - +0 LOAD (R/W). Writing also sets COUNT <= DOUT.
  - +1 CTRL (R/W). Bit0 EN, bit1 AUTO; other bits read 0.
  - +2 COUNT (read-only).
  - +3 STATUS (R/W1C). Bit0 EXP.
- Timer state machine (per edge, EN=1, no write to LOAD this cycle):
  - COUNT>1: COUNT <= COUNT-1.
  - COUNT==1: COUNT <= 0 and EXP <= 1. If AUTO=1, COUNT <= LOAD on the following edge and counting continues; if AUTO=0, EN <= 0 on the same edge.
  - COUNT==0 with EN=1 (e.g. LOAD=0): EXP <= 1; then same AUTO/EN handling as the COUNT==1 case.
  - Wrap-around below 0 never happens.
- Timer priority and side rules:
  - A LOAD write in the same cycle overrides the decrement.
  - A CTRL write in the same cycle as auto-disable: the written value wins.
  - EXP set and a W1C clear in the same cycle: set wins.
  - tmr_irq = EXP.
  - EN=0 freezes COUNT.
- Reset mid-operation: everything returns to reset values asynchronously. The counter stops. An in-flight write is lost.

Decomposition:
- Package mem_map_pkg holds:
  - LED_ADDR, TMR_BASE and SW_ADDR defaults;
  - timer offsets (LOAD=0, CTRL=1, COUNT=2, STAT=3);
  - CTRL bit indices (EN=0, AUTO=1);
  - STATUS bit index (EXP=0).
- One sub-module: timer16. It contains LOAD, COUNT, CTRL and STATUS, the decrement/reload state machine and register write decode. Its interface is a 2-bit offset, wr, wdata, rdata and irq.
- The top level keeps the RAM array, the address decode, the read mux and the DIN register, the LED register and the switch synchroniser.

Test Plan:
- RAM write/read: write 16'hBEEF to 0x0005 (W=1 one cycle), then ADDR=0x0005, W=0 -> DIN=16'hBEEF exactly one edge later. Read 0x0006 (unwritten, after prior init write of 0) -> DIN=0.
- Read-first: write 16'h1234 to 0x0010, then W=1 with 16'h5678 to 0x0010 while reading it -> DIN=16'h1234 that cycle; next read returns 16'h5678.
- Map/unmapped: write 16'h03FF to LED_ADDR -> LEDR=10'h3FF, and a read returns 16'h03FF. Write to 0x4000 -> nothing changes; read 0x4000 -> DIN=0. SW=10'h155 -> SW_ADDR read is 16'h0155 no earlier than 3 edges after the SW change.
- Timer one-shot: LOAD=3, CTRL=1 -> COUNT reads 2,1,0 on successive edges; tmr_irq rises on the edge where COUNT becomes 0; CTRL reads 0 afterwards. Write 1 to STATUS -> tmr_irq=0.
- Timer auto-reload and priority: LOAD=2, CTRL=3 -> tmr_irq periodic, COUNT sequence 1,0,2,1,0,... Issue a W1C on the same edge EXP is set -> EXP stays 1.
- Async reset: assert resetN mid-count (COUNT=5, LEDR=10'h0AA) between edges -> DIN, LEDR, COUNT, CTRL and tmr_irq become 0 immediately. After release, RAM still holds 16'hBEEF at 0x0005.
